// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch initiator.
//
// Drives the instruction memory read port with the current PC each cycle and
// delivers an in-order stream of {inst, inst_pc} to decode. imem has a fixed
// 1-cycle read latency and no stall input. A request is only issued when the
// buffer is guaranteed to have room for its response. So a returning word
// always has a slot, and no response is ever dropped.
//
// Optional feature: define FETCH_MISALIGN_EN to add the inst_fault port and
// the misaligned-redirect fault path. Without it, the low two bits of
// redirect_pc are cleared when the new PC is loaded.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   imem_addr      byte address to imem (always equals pc_q)
//   imem_rdata     imem word for the address presented in the previous cycle
//   redirect_valid load redirect_pc and flush all buffered/in-flight words
//   redirect_pc    redirect target
//   inst_valid     buffer head holds a valid instruction
//   inst           instruction word at the buffer head
//   inst_pc        PC of inst
//   inst_ready     decode accepts the head (transfer = inst_valid & inst_ready)
//   inst_fault     head entry is a misaligned-fetch fault (FETCH_MISALIGN_EN)
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
`ifdef FETCH_MISALIGN_EN
  output logic            inst_fault,
`endif
  input  logic            inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;   // count spans 0..DEPTH
  localparam int OW = CW + 1;   // count + in-flight headroom

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            inflight_q;

  logic [XLEN-1:0] buf_inst [DEPTH];
  logic [XLEN-1:0] buf_pc   [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;

  logic            pop;
  logic            push;
  logic            issue;
  logic [OW-1:0]   occupancy;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] push_inst;

`ifdef FETCH_MISALIGN_EN
  logic buf_fault [DEPTH];
  logic fault_pend_q;   // next issued request is the misaligned fault request
  logic req_fault_q;    // the in-flight request is the fault request
  logic halt_q;         // fault request issued; stop until redirect/reset
  logic misaligned;

  assign misaligned      = |redirect_pc[1:0];
  assign redirect_target = redirect_pc;
  // The fault entry carries no memory data.
  assign push_inst       = req_fault_q ? '0 : imem_rdata;
  assign inst_fault      = buf_fault[rd_ptr_q];
`else
  logic [1:0] unused_redirect_lo;

  assign unused_redirect_lo = redirect_pc[1:0];
  assign redirect_target    = {redirect_pc[XLEN-1:2], 2'b00};
  assign push_inst          = imem_rdata;
`endif

  assign imem_addr = pc_q;

  // Redirect masks the head so that no stale word can be consumed in the
  // cycle the flush is taking effect.
  assign inst_valid = (count_q != '0) && !redirect_valid;
  assign inst       = buf_inst[rd_ptr_q];
  assign inst_pc    = buf_pc[rd_ptr_q];

  assign pop  = inst_valid && inst_ready;
  // A response whose request was outstanding at a redirect is dropped.
  // inflight_q is cleared at that edge, so the next cycle ignores it too.
  assign push = inflight_q && !redirect_valid;

  // Credit check: every slot that will be occupied once the in-flight word
  // lands must fit, counting the slot freed by this cycle's pop.
  assign occupancy = OW'(count_q) + OW'(inflight_q) - OW'(pop);

  always_comb begin
    issue = !redirect_valid && (occupancy < OW'(DEPTH));
`ifdef FETCH_MISALIGN_EN
    if (halt_q) issue = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
`ifdef FETCH_MISALIGN_EN
        buf_fault[i] <= 1'b0;
`endif
      end
`ifdef FETCH_MISALIGN_EN
      fault_pend_q <= 1'b0;
      req_fault_q  <= 1'b0;
      halt_q       <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc_q       <= redirect_target;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
`ifdef FETCH_MISALIGN_EN
      fault_pend_q <= misaligned;
      req_fault_q  <= 1'b0;
      halt_q       <= 1'b0;
`endif
    end else begin
      // Stage p0: issue the address of pc_q
      if (issue) begin
        inflight_q <= 1'b1;
        req_pc_q   <= pc_q;
        pc_q       <= pc_q + XLEN'(4);
`ifdef FETCH_MISALIGN_EN
        req_fault_q <= fault_pend_q;
        if (fault_pend_q) begin
          fault_pend_q <= 1'b0;
          halt_q       <= 1'b1;
        end
`endif
      end else begin
        inflight_q <= 1'b0;
      end

      // Stage p1: capture the returning word into the buffer tail
      if (push) begin
        buf_inst[wr_ptr_q] <= push_inst;
        buf_pc[wr_ptr_q]   <= req_pc_q;
`ifdef FETCH_MISALIGN_EN
        buf_fault[wr_ptr_q] <= req_fault_q;
`endif
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end

      // Stage p2: head consumed by decode
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);

      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef FETCH_MISALIGN_EN
  logic        inst_fault;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
`ifdef FETCH_MISALIGN_EN
    .inst_fault(inst_fault),
`endif
    .inst_ready(inst_ready)
  );

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0) return 32'h0000_0013;
    if (w == 32'h4) return 32'h0010_0093;
    return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // 1-cycle synchronous read memory.
  always @(posedge clk) imem_rdata <= word_at(imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc;
  bit          model_halt;
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          passes = 0;
  int          xfer_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference stream: after a reset/redirect to P, decode sees P, P+4, ...
  // (mod 2^32), or a single fault entry for a misaligned target when enabled.
  task automatic top_up();
    exp_t e;
    while (!model_halt && exp_q.size() < 8) begin
      e.pc    = model_pc;
      e.inst  = word_at(model_pc);
      e.fault = 1'b0;
      exp_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic model_start(input logic [31:0] pc);
    exp_t e;
    exp_q.delete();
`ifdef FETCH_MISALIGN_EN
    if (pc[1:0] != 2'b00) begin
      e.pc    = pc;
      e.inst  = 32'h0;
      e.fault = 1'b1;
      exp_q.push_back(e);
      model_halt = 1'b1;
      return;
    end
`else
    pc[1:0] = 2'b00;
`endif
    model_halt = 1'b0;
    model_pc   = pc;
    top_up();
  endtask

  // Monitor: every transfer pops the scoreboard and is compared.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n && inst_valid && inst_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_xfer: got pc %h expected no transfer", inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst", inst, e.inst);
`ifdef FETCH_MISALIGN_EN
        chk("inst_fault", {31'b0, inst_fault}, {31'b0, e.fault});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    top_up();
  endtask

  initial begin
    int x0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    model_halt     = 1'b1;
    model_pc       = 32'h0;
    repeat (3) tick();

    // Reset state
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // Release with decode always ready: valid 2 cycles later, then 1/cycle
    model_start(32'h0);
    mon_en     = 1'b1;
    inst_ready = 1'b1;
    rst_n      = 1'b1;
    tick();
    chk("first_t1_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("first_t2_valid", {31'b0, inst_valid}, 32'd1);
    chk("first_inst", inst, 32'h0000_0013);
    tick();
    chk("second_inst", inst, 32'h0010_0093);
    chk("second_pc", inst_pc, 32'h4);
    x0 = xfer_cnt;
    repeat (8) tick();
    chk("throughput", xfer_cnt - x0, 32'd8);

    // Back-pressure from the first valid cycle
    rst_n      = 1'b0;
    inst_ready = 1'b0;
    model_start(32'h0);
    tick();
    rst_n = 1'b1;
    chk("rst_clears_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    tick();
    chk("bp_first_valid", {31'b0, inst_valid}, 32'd1);
    repeat (5) tick();
    chk("bp_addr_stall", imem_addr, 32'h8);
    chk("bp_head_pc", inst_pc, 32'h0);
    x0 = xfer_cnt;
    inst_ready = 1'b1;
    repeat (3) tick();
    chk("bp_drain", xfer_cnt - x0, 32'd3);

    // Reset mid-stream while the buffer is full
    inst_ready = 1'b0;
    repeat (4) tick();
    chk("full_valid", {31'b0, inst_valid}, 32'd1);
    rst_n = 1'b0;
    model_start(32'h0);
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", {31'b0, inst_valid}, 32'd0);
    chk("midrst_inst_pc", inst_pc, 32'h0);
    chk("midrst_inst", inst, 32'h0);
    inst_ready = 1'b1;
    repeat (4) tick();

    // Redirect while the buffer is full
    inst_ready = 1'b0;
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    inst_ready     = 1'b1;
    model_start(32'h40);
    #1;
    chk("redir_valid_forced", {31'b0, inst_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    chk("redir_addr", imem_addr, 32'h40);
    tick();
    chk("redir_lat_t1", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("redir_lat_t2", {31'b0, inst_valid}, 32'd1);
    chk("redir_pc", inst_pc, 32'h40);
    repeat (4) tick();

    // PC wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    model_start(32'hFFFF_FFF8);
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    model_start(32'h42);
    tick();
    redirect_valid = 1'b0;
    x0 = xfer_cnt;
    repeat (8) tick();
`ifdef FETCH_MISALIGN_EN
    chk("fault_single", xfer_cnt - x0, 32'd1);
    chk("fault_halt_valid", {31'b0, inst_valid}, 32'd0);
`else
    chk("misalign_stream", xfer_cnt - x0, 32'd6);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    model_start(32'h80);
    tick();
    redirect_valid = 1'b0;
    x0 = xfer_cnt;
    repeat (8) tick();
    chk("resume_0x80", xfer_cnt - x0, 32'd6);

    // Randomized traffic with redirects (including back-to-back) and resets
    x0 = xfer_cnt;
    for (int i = 0; i < 3000; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = 1'b0;
      rst_n          = 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        rst_n      = 1'b0;
        inst_ready = 1'b0;
        model_start(32'h0);
      end else if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom();
        if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
        model_start(redirect_pc);
        #1;
        chk("rnd_redir_valid", {31'b0, inst_valid}, 32'd0);
      end
      tick();
    end
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    chk("rnd_progress", {31'b0, (xfer_cnt - x0) > 500}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
